// File: rtl/mask_pkg.sv
// Shared types and sizes for the mask writeback unit.
// Included by the interface, the lane merge and the top.
package mask_pkg;

  localparam int VLEN     = 128;
  localparam int LANES    = 4;
  localparam int MAX_UOPS = VLEN / LANES;
  localparam int VL_W     = 8;
  localparam int CNT_W    = 6;
  localparam int UOPN_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WRITE
  } mask_wb_state_t;

  function automatic logic [VL_W-1:0] clamp_vl(
    input logic [VL_W-1:0] vl
  );
    return (vl > 8'd128) ? 8'd128 : vl;
  endfunction

endpackage

// File: rtl/mask_writeback_unit_if.sv
// Start / uop / writeback handshake bundle.
// master drives requests, slave is the writeback unit.
interface mask_writeback_unit_if;
  import mask_pkg::*;

  logic                 start;
  logic                 start_ready;
  logic [VL_W-1:0]      vl;
  logic                 mask_enable;
  logic [VLEN-1:0]      v0;
  logic [VLEN-1:0]      old_vd;
  logic                 uop_valid;
  logic                 uop_ready;
  logic [UOPN_W-1:0]    uop_num;
  logic [LANES-1:0]     lane_result;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [VLEN-1:0]      wb_data;
  logic                 seq_err;

  modport master (
    output start, vl, mask_enable, v0, old_vd,
    output uop_valid, uop_num, lane_result,
    output wb_ready,
    input  start_ready, uop_ready,
    input  wb_valid, wb_data, seq_err
  );

  modport slave (
    input  start, vl, mask_enable, v0, old_vd,
    input  uop_valid, uop_num, lane_result,
    input  wb_ready,
    output start_ready, uop_ready,
    output wb_valid, wb_data, seq_err
  );

endinterface

// File: rtl/mask_lane_merge.sv
// Merges one uop of lane results into the mask image.
// Body/active lanes take the result, others stay undisturbed.
module mask_lane_merge
  import mask_pkg::*;
(
  input  logic [VLEN-1:0]   i_acc,
  input  logic [UOPN_W-1:0] i_uop_num,
  input  logic [LANES-1:0]  i_lane_result,
  input  logic [VLEN-1:0]   i_v0,
  input  logic [VL_W-1:0]   i_vl,
  input  logic              i_mask_enable,
  output logic [VLEN-1:0]   o_acc
);

  logic [6:0]       w_idx [LANES];
  logic [LANES-1:0] w_en;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_idx[g] = {i_uop_num, 2'b00} + 7'(g);
    assign w_en[g]  = ({1'b0, w_idx[g]} < i_vl) &&
                      (!i_mask_enable || i_v0[w_idx[g]]);
  end

  // overlay qualified lanes on the current image
  always_comb begin
    o_acc = i_acc;
    for (int i = 0; i < LANES; i++) begin
      if (w_en[i]) o_acc[w_idx[i]] = i_lane_result[i];
    end
  end

endmodule

// File: rtl/mask_writeback_unit.sv
// Collects per-uop compare bits into a mask register
// image and hands it to the register-file write port.
module mask_writeback_unit
  import mask_pkg::*;
(
  input logic                  CLK,
  input logic                  RST,
  mask_writeback_unit_if.slave bus
);

  mask_wb_state_t    r_state;
  mask_wb_state_t    w_next;
  logic [VLEN-1:0]   r_acc;
  logic [VLEN-1:0]   r_v0;
  logic [VL_W-1:0]   r_vl;
  logic              r_me;
  logic [CNT_W-1:0]  r_n_uops;
  logic [CNT_W-1:0]  r_uop_cnt;
  logic              r_seq_err;

  logic [VL_W-1:0]   w_vl_c;
  logic [8:0]        w_sum;
  logic [CNT_W-1:0]  w_n_uops;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_start_acc;
  logic              w_uop_acc;
  logic [VLEN-1:0]   w_acc_nxt;

  assign w_vl_c      = clamp_vl(bus.vl);
  assign w_sum       = {1'b0, w_vl_c} + 9'd3;
  assign w_n_uops    = w_sum[7:2];
  assign w_cnt_inc   = r_uop_cnt + 6'd1;
  assign w_start_acc = (r_state == IDLE) && bus.start;
  assign w_uop_acc   = (r_state == ACCUM) && bus.uop_valid;

  mask_lane_merge u_merge (
    .i_acc         (r_acc),
    .i_uop_num     (bus.uop_num),
    .i_lane_result (bus.lane_result),
    .i_v0          (r_v0),
    .i_vl          (r_vl),
    .i_mask_enable (r_me),
    .o_acc         (w_acc_nxt)
  );

  // next-state selection
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (bus.start)
          w_next = (w_n_uops == '0) ? WRITE : ACCUM;
      ACCUM:
        if (bus.uop_valid && (w_cnt_inc == r_n_uops))
          w_next = WRITE;
      WRITE:
        if (bus.wb_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state, latched operands, accumulator and counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_v0      <= '0;
      r_vl      <= '0;
      r_me      <= 1'b0;
      r_n_uops  <= '0;
      r_uop_cnt <= '0;
      r_seq_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_acc     <= bus.old_vd;
        r_v0      <= bus.v0;
        r_vl      <= w_vl_c;
        r_me      <= bus.mask_enable;
        r_n_uops  <= w_n_uops;
        r_uop_cnt <= '0;
        r_seq_err <= 1'b0;
      end else if (w_uop_acc) begin
        r_acc     <= w_acc_nxt;
        r_uop_cnt <= w_cnt_inc;
        if (bus.uop_num != r_uop_cnt[4:0])
          r_seq_err <= 1'b1;
      end
    end
  end

  assign bus.start_ready = (r_state == IDLE);
  assign bus.uop_ready   = (r_state == ACCUM);
  assign bus.wb_valid    = (r_state == WRITE);
  assign bus.wb_data     = r_acc;
  assign bus.seq_err     = r_seq_err;

endmodule

// File: tb/tb_mask_writeback_unit.sv
// Randomized + directed bench for mask_writeback_unit.
// Reference: element-wise mask merge on a 128-bit image.
module tb_mask_writeback_unit;
  import mask_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [127:0] m_acc;
  bit           m_err;

  mask_writeback_unit_if bus();

  mask_writeback_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic quiet();
    bus.start       = 1'b0;
    bus.vl          = '0;
    bus.mask_enable = 1'b0;
    bus.v0          = '0;
    bus.old_vd      = '0;
    bus.uop_valid   = 1'b0;
    bus.uop_num     = '0;
    bus.lane_result = '0;
    bus.wb_ready    = 1'b0;
  endtask

  task automatic begin_instr(input int vl_in, input bit me,
                             input logic [127:0] v0,
                             input logic [127:0] old);
    m_acc = old;
    m_err = 0;
    chk("start_ready_idle", bus.start_ready, 1);
    bus.start       = 1'b1;
    bus.vl          = 8'(vl_in);
    bus.mask_enable = me;
    bus.v0          = v0;
    bus.old_vd      = old;
    step();
    bus.start  = 1'b0;
    bus.v0     = rnd128();
    bus.old_vd = rnd128();
    bus.vl     = 8'($urandom);
    chk("start_taken", bus.start_ready, 0);
    chk("seq_err_clear", bus.seq_err, 0);
  endtask

  task automatic send_uop(input int num, input int k,
                          input logic [3:0] lr,
                          input int vlc, input bit me,
                          input logic [127:0] v0);
    int idx;
    bus.uop_valid   = 1'b1;
    bus.uop_num     = 5'(num);
    bus.lane_result = lr;
    for (int i = 0; i < 4; i++) begin
      idx = num * 4 + i;
      if (idx < vlc && (!me || v0[idx])) m_acc[idx] = lr[i];
    end
    if (num != k) m_err = 1;
    step();
    bus.uop_valid   = 1'b0;
    bus.lane_result = 4'($urandom);
    chk("seq_err", bus.seq_err, m_err);
  endtask

  task automatic run_instr(input int vl_in, input bit me,
                           input logic [127:0] v0,
                           input logic [127:0] old,
                           input int mode, input int hold,
                           input bit bub, input int fix_lr,
                           input bit use_d,
                           input logic [127:0] dexp);
    int vlc;
    int n;
    int order[$];
    int tmp;
    logic [3:0] lr;
    vlc = (vl_in > 128) ? 128 : vl_in;
    n   = (vlc + 3) / 4;
    begin_instr(vl_in, me, v0, old);
    for (int k = 0; k < n; k++) order.push_back(k);
    if (mode == 1 && n >= 2) begin
      tmp = order[0]; order[0] = order[1]; order[1] = tmp;
    end
    if (mode == 2)
      for (int k = 0; k < n; k++)
        order[k] = $urandom_range(0, 31);
    if (n == 0) chk("vl0_wb_valid", bus.wb_valid, 1);
    else chk("accum_ready", bus.uop_ready, 1);
    for (int k = 0; k < n; k++) begin
      if (bub && $urandom_range(0, 2) == 0) begin
        step();
        chk("bubble_ready", bus.uop_ready, 1);
        chk("bubble_wbv", bus.wb_valid, 0);
      end
      lr = (fix_lr >= 0) ? 4'(fix_lr) : 4'($urandom);
      send_uop(order[k], k, lr, vlc, me, v0);
      if (k < n - 1) begin
        chk("mid_wbv", bus.wb_valid, 0);
        chk("mid_ready", bus.uop_ready, 1);
      end else begin
        chk("last_wbv", bus.wb_valid, 1);
        chk("last_ready", bus.uop_ready, 0);
      end
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", bus.wb_valid, 1);
      chk("hold_data", bus.wb_data, m_acc);
      chk("hold_sready", bus.start_ready, 0);
      bus.start       = 1'b1;
      bus.uop_valid   = 1'b1;
      bus.uop_num     = 5'($urandom);
      bus.lane_result = 4'($urandom);
      step();
    end
    bus.uop_valid = 1'b0;
    chk("wb_data", bus.wb_data, m_acc);
    if (use_d) chk("wb_data_dir", bus.wb_data, dexp);
    bus.wb_ready = 1'b1;
    bus.start    = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    bus.start    = 1'b0;
    chk("post_sready", bus.start_ready, 1);
    chk("post_wbv", bus.wb_valid, 0);
    chk("post_seq_err", bus.seq_err, m_err);
  endtask

  task automatic reset_mid_accum();
    logic [127:0] v0;
    v0 = rnd128();
    begin_instr(128, 1'b0, v0, '0);
    for (int k = 0; k < 3; k++)
      send_uop(k, k, 4'($urandom), 128, 1'b0, v0);
    RST           = 1'b1;
    bus.uop_valid = 1'b1;
    step();
    RST           = 1'b0;
    bus.uop_valid = 1'b0;
    chk("rst_sready", bus.start_ready, 1);
    chk("rst_wbv", bus.wb_valid, 0);
    chk("rst_uready", bus.uop_ready, 0);
    chk("rst_seq_err", bus.seq_err, 0);
  endtask

  initial begin
    logic [127:0] v0;
    logic [127:0] old;
    quiet();
    RST = 1'b1;
    step();
    step();
    chk("reset_sready", bus.start_ready, 1);
    chk("reset_wbv", bus.wb_valid, 0);
    chk("reset_uready", bus.uop_ready, 0);
    chk("reset_seq_err", bus.seq_err, 0);
    RST = 1'b0;
    bus.uop_valid = 1'b1;
    step();
    bus.uop_valid = 1'b0;
    chk("idle_uop_ignored", bus.uop_ready, 0);

    run_instr(128, 0, '0, '0, 0, 0, 0, 'hA, 1,
              {32{4'hA}});
    run_instr(6, 0, '0, '1, 0, 1, 0, 0, 1,
              {{122{1'b1}}, 6'b0});
    v0 = 128'h55;
    run_instr(8, 1, v0, '0, 0, 0, 0, 'hF, 1,
              128'h55);
    old = rnd128();
    run_instr(0, 0, rnd128(), old, 0, 3, 0, -1, 1, old);
    run_instr(8, 0, '0, '0, 1, 1, 0, -1, 0, '0);
    run_instr(200, 0, '0, '1, 0, 0, 0, 0, 1, '0);
    reset_mid_accum();
    run_instr(13, 0, '0, '0, 0, 0, 0, 'hF, 1,
              128'h1FFF);

    for (int t = 0; t < 40; t++) begin
      run_instr($urandom_range(0, 255),
                1'($urandom), rnd128(), rnd128(),
                $urandom_range(0, 2),
                $urandom_range(0, 3), 1'b1, -1,
                1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
